// File: rtl/ahb_multi_master_arbiter_pkg.sv
// ahb_pkg: shared definitions for the multi-master AHB-Lite front end.
//   - HTRANS_IDLE / HTRANS_NONSEQ : transfer-type encodings driven on htrans
//   - HRESP_OKAY / HRESP_ERROR    : slave response encodings sampled on hresp
//   - state_e                     : transfer sequencer states IDLE/ADDR/DATA/DONE
//   - is_onehot()                 : slave-select validity check (up to 64 bits)
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int ONEHOT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Callers zero-extend narrower selects; extra zero bits do not change the result.
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/ahb_multi_master_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin requester selection with an internal priority pointer.
//   clk, reset  : clock and synchronous active-high reset (pointer -> N-1)
//   req_i       : request vector, one bit per channel
//   upd_i       : strobe; loads the pointer with upd_idx_i
//   upd_idx_i   : index of the channel that was just served
//   grant_o     : first requesting channel after the pointer (wrapping)
//   any_o       : at least one request is present
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          upd_i,
  input  logic [IW-1:0] upd_idx_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q;

  // Pointer starts at the last channel so channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= IW'(N - 1);
    end else if (upd_i) begin
      ptr_q <= upd_idx_i;
    end
  end

  // Walk offsets from the far end back towards ptr+1 so the nearest
  // requester after the pointer is the last (winning) assignment.
  always_comb begin
    int            sum;
    logic [IW-1:0] idx;
    grant_o = ptr_q;
    any_o   = |req_i;
    sum     = 0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      sum = int'(ptr_q) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = IW'(sum);
      if (req_i[idx]) begin
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/ahb_multi_master_arbiter.sv
// ahb_multi_master_arbiter: round-robin front end issuing one non-pipelined
// AHB-Lite transfer per local request and returning data/status to the
// requesting channel.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req/addr/din/wcontrol/slave_sel : per-channel request (flattened buses)
//   done/dout/err        : completion pulse, read data and error back to channels
//   haddr/htrans/hwrite/hwdata/hsel : AHB master-side outputs
//   hrdata/hready/hresp  : AHB slave-side inputs
// Optional build macro AHB_TIMEOUT_EN: adds a wait-state counter that ends a
// stalled transfer with err=1 after TIMEOUT_CYCLES cycles of hready=0.
module ahb_multi_master_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_MASTERS-1:0]             req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]      addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]      din,
  input  logic [NUM_MASTERS-1:0]             wcontrol,
  input  logic [NUM_MASTERS*NUM_SLAVES-1:0]  slave_sel,
  output logic [NUM_MASTERS-1:0]             done,
  output logic [DATA_W-1:0]                  dout,
  output logic                               err,
  output logic [ADDR_W-1:0]                  haddr,
  output logic [1:0]                         htrans,
  output logic                               hwrite,
  output logic [DATA_W-1:0]                  hwdata,
  output logic [NUM_SLAVES-1:0]              hsel,
  input  logic [DATA_W-1:0]                  hrdata,
  input  logic                               hready,
  input  logic                               hresp
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Per-channel views of the flattened request buses.
  logic [ADDR_W-1:0]     addr_a [NUM_MASTERS];
  logic [DATA_W-1:0]     din_a  [NUM_MASTERS];
  logic [NUM_SLAVES-1:0] sel_a  [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_ch
    assign addr_a[gi] = addr[gi*ADDR_W +: ADDR_W];
    assign din_a[gi]  = din[gi*DATA_W +: DATA_W];
    assign sel_a[gi]  = slave_sel[gi*NUM_SLAVES +: NUM_SLAVES];
  end

  state_e                 state_q;
  logic [IW-1:0]          grant_q;
  logic [DATA_W-1:0]      din_q;
  logic                   wr_q;
  logic [NUM_MASTERS-1:0] done_q;
  logic [DATA_W-1:0]      dout_q;
  logic                   err_q;
  logic [ADDR_W-1:0]      haddr_q;
  logic [1:0]             htrans_q;
  logic                   hwrite_q;
  logic [DATA_W-1:0]      hwdata_q;
  logic [NUM_SLAVES-1:0]  hsel_q;

  logic [IW-1:0]          grant_d;
  logic                   any_req;
  logic                   win_onehot;
  logic                   timeout;

  rr_arbiter #(
    .N(NUM_MASTERS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .upd_i     (state_q == DONE),
    .upd_idx_i (grant_q),
    .grant_o   (grant_d),
    .any_o     (any_req)
  );

  assign win_onehot = is_onehot(ONEHOT_MAX_W'(sel_a[grant_d]));

`ifdef AHB_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCNT_W-1:0] wait_q;

  // Held at zero in IDLE, so it always starts from zero on ADDR entry.
  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE) begin
      wait_q <= '0;
    end else if ((state_q == ADDR || state_q == DATA) && !hready) begin
      wait_q <= wait_q + WCNT_W'(1);
    end
  end

  // Fires on the cycle that would be the TIMEOUT_CYCLES-th stalled cycle.
  assign timeout = (state_q == ADDR || state_q == DATA) && !hready &&
                   (wait_q == WCNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No counter in this build: waits are unbounded and TIMEOUT_CYCLES has no effect.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      done_q   <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      hsel_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= grant_d;
            din_q   <= din_a[grant_d];
            wr_q    <= wcontrol[grant_d];
            if (win_onehot) begin
              state_q  <= ADDR;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= addr_a[grant_d];
              hwrite_q <= wcontrol[grant_d];
              hsel_q   <= sel_a[grant_d];
            end else begin
              // Invalid select: complete with an error, never touch the bus.
              state_q         <= DONE;
              done_q[grant_d] <= 1'b1;
              err_q           <= 1'b1;
              dout_q          <= '0;
            end
          end
        end
        ADDR: begin
          if (timeout) begin
            state_q         <= DONE;
            done_q[grant_q] <= 1'b1;
            err_q           <= 1'b1;
            dout_q          <= '0;
            htrans_q        <= HTRANS_IDLE;
            hsel_q          <= '0;
          end else if (hready) begin
            state_q  <= DATA;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= din_q;
          end
        end
        DATA: begin
          if (timeout) begin
            state_q         <= DONE;
            done_q[grant_q] <= 1'b1;
            err_q           <= 1'b1;
            dout_q          <= '0;
            hsel_q          <= '0;
          end else if (hready) begin
            state_q         <= DONE;
            done_q[grant_q] <= 1'b1;
            dout_q          <= wr_q ? '0 : hrdata;
            err_q           <= (hresp == HRESP_ERROR);
            hsel_q          <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign dout   = dout_q;
  assign err    = err_q;
  assign haddr  = haddr_q;
  assign htrans = htrans_q;
  assign hwrite = hwrite_q;
  assign hwdata = hwdata_q;
  assign hsel   = hsel_q;

endmodule

// File: tb/tb_ahb_multi_master_arbiter.sv
// Self-checking bench for ahb_multi_master_arbiter: a table of single-channel
// transfers plus hand-written contention, reset-abort and long-wait sequences.
// When AHB_TIMEOUT_EN is defined the DUT is built with TIMEOUT_CYCLES=8 and the
// long-wait sequence checks the timeout completion instead.
module tb_ahb_multi_master_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
`ifdef AHB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     req;
  logic [NM*AW-1:0]  addr;
  logic [NM*DW-1:0]  din;
  logic [NM-1:0]     wcontrol;
  logic [NM*NS-1:0]  slave_sel;
  logic [NM-1:0]     done;
  logic [DW-1:0]     dout;
  logic              err;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [DW-1:0]     hwdata;
  logic [NS-1:0]     hsel;
  logic [DW-1:0]     hrdata;
  logic              hready;
  logic              hresp;

  always #5 clk = ~clk;

  ahb_multi_master_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr      (addr),
    .din       (din),
    .wcontrol  (wcontrol),
    .slave_sel (slave_sel),
    .done      (done),
    .dout      (dout),
    .err       (err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hsel      (hsel),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          ch;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] rd;
    logic        resp;
    int          nwait;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic        exp_err;
    int          exp_lat;
    int          exp_nonseq;
  } vec_t;

  vec_t vecs[7];

  task automatic set_ch(input int ch, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sel);
    addr[ch*AW +: AW]      = a;
    din[ch*DW +: DW]       = wd;
    wcontrol[ch]           = wr;
    slave_sel[ch*NS +: NS] = sel;
  endtask

  // One request from one channel; a simple slave answers with v.nwait data-phase waits.
  task automatic run_txn(input int n, input vec_t v);
    int            cyc;
    int            waits;
    int            nonseq;
    bit            got;
    bit            in_data;
    logic [NM-1:0] exp_done;
    exp_done       = '0;
    exp_done[v.ch] = 1'b1;
    set_ch(v.ch, v.wr, v.a, v.wd, v.sel);
    req[v.ch] = 1'b1;
    hready = 1'b1; hrdata = '0; hresp = 1'b0;
    waits = v.nwait; got = 0; in_data = 0; nonseq = 0; cyc = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        got = 1;
        check($sformatf("v%0d done", n), 64'(done), 64'(exp_done));
        check($sformatf("v%0d err", n), 64'(err), 64'(v.exp_err));
        if (v.chk_dout) check($sformatf("v%0d dout", n), 64'(dout), 64'(v.exp_dout));
        check($sformatf("v%0d latency", n), 64'(cyc), 64'(v.exp_lat));
        check($sformatf("v%0d nonseq cycles", n), 64'(nonseq), 64'(v.exp_nonseq));
        check($sformatf("v%0d hsel at done", n), 64'(hsel), 64'(0));
        check($sformatf("v%0d htrans at done", n), 64'(htrans), 64'(2'b00));
        $display("txn %0d ch=%0d wr=%0b lat=%0d dout=0x%08h err=%0b", n, v.ch, v.wr, cyc, dout, err);
        req[v.ch] = 1'b0;
      end else if (htrans == 2'b10) begin
        nonseq++;
        check($sformatf("v%0d haddr", n), 64'(haddr), 64'(v.a));
        check($sformatf("v%0d hwrite", n), 64'(hwrite), 64'(v.wr));
        check($sformatf("v%0d hsel addr", n), 64'(hsel), 64'(v.sel));
        // Changing the granted channel's data now must not reach hwdata.
        din[v.ch*DW +: DW] = ~v.wd;
        hready  = 1'b1;
        in_data = 1;
      end else if (in_data) begin
        if (v.wr) check($sformatf("v%0d hwdata", n), 64'(hwdata), 64'(v.wd));
        check($sformatf("v%0d hsel data", n), 64'(hsel), 64'(v.sel));
        if (waits > 0) begin
          hready = 1'b0;
          waits--;
        end else begin
          hready = 1'b1;
          hrdata = v.rd;
          hresp  = v.resp;
        end
      end
    end
    if (!got) check($sformatf("v%0d done within bound", n), 64'(0), 64'(1));
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    @(negedge clk);
    check($sformatf("v%0d done single pulse", n), 64'(done), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int            cyc;
    int            ndone;
    int            last_cyc;
    int            hits;
    int            exp_order[4];
    logic [NM-1:0] exp_done;

    //           ch wr    addr        wdata        sel      rdata        rsp  w  chk  exp_dout     err  lat ns
    vecs[0] = '{1, 1'b0, 32'h10, 32'h0,        4'b0010, 32'hDEADBEEF, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1};
    vecs[1] = '{0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b0001, 32'h12345678, 1'b0, 2, 1'b1, 32'h0,        1'b0, 5, 1};
    vecs[2] = '{2, 1'b0, 32'h30, 32'h0,        4'b1000, 32'hCAFEF00D, 1'b1, 0, 1'b1, 32'hCAFEF00D, 1'b1, 3, 1};
    vecs[3] = '{1, 1'b0, 32'h40, 32'h0,        4'b0110, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[4] = '{0, 1'b0, 32'h50, 32'h0,        4'b0000, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b1, 1, 0};
    vecs[5] = '{2, 1'b1, 32'h60, 32'h3C3C0F0F, 4'b0100, 32'hFFFFFFFF, 1'b0, 1, 1'b1, 32'h0,        1'b0, 4, 1};
    vecs[6] = '{1, 1'b0, 32'h74, 32'h0,        4'b0001, 32'h00000001, 1'b0, 1, 1'b1, 32'h00000001, 1'b0, 4, 1};

    reset = 1'b1; req = '0; addr = '0; din = '0; wcontrol = '0; slave_sel = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    repeat (3) @(negedge clk);
    check("reset done",   64'(done),   64'(0));
    check("reset dout",   64'(dout),   64'(0));
    check("reset err",    64'(err),    64'(0));
    check("reset haddr",  64'(haddr),  64'(0));
    check("reset htrans", 64'(htrans), 64'(0));
    check("reset hwrite", 64'(hwrite), 64'(0));
    check("reset hwdata", 64'(hwdata), 64'(0));
    check("reset hsel",   64'(hsel),   64'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(i, vecs[i]);
    end

    // Contention: all three channels request continuously from a fresh pointer.
    do_reset();
    for (int c = 0; c < NM; c++) set_ch(c, 1'b0, 32'h100 + 32'(c * 4), 32'h11110000 + 32'(c), 4'b0001);
    hrdata = 32'h00005555;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;
    req = 3'b111;
    cyc = 0; ndone = 0; last_cyc = 0;
    while (ndone < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        exp_done = '0;
        exp_done[exp_order[ndone]] = 1'b1;
        check($sformatf("rr grant %0d", ndone), 64'(done), 64'(exp_done));
        check($sformatf("rr spacing %0d", ndone), 64'(cyc - last_cyc), 64'((ndone == 0) ? 3 : 4));
        $display("txn rr%0d done=%b cycle=%0d dout=0x%08h", ndone, done, cyc, dout);
        last_cyc = cyc;
        ndone++;
        if (ndone == 4) req = '0;
      end
    end
    if (ndone < 4) check("rr done count", 64'(ndone), 64'(4));
    @(negedge clk);

    // Reset during a data-phase wait: abandoned with no done, outputs cleared.
    set_ch(2, 1'b1, 32'h44, 32'h0BADF00D, 4'b0001);
    req[2] = 1'b1;
    @(negedge clk);
    check("rst seq addr phase", 64'(htrans), 64'(2'b10));
    @(negedge clk);
    hready = 1'b0;
    @(negedge clk);
    check("rst seq waiting done", 64'(done), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rst seq done",   64'(done),   64'(0));
    check("rst seq htrans", 64'(htrans), 64'(0));
    check("rst seq hsel",   64'(hsel),   64'(0));
    check("rst seq haddr",  64'(haddr),  64'(0));
    check("rst seq hwrite", 64'(hwrite), 64'(0));
    check("rst seq hwdata", 64'(hwdata), 64'(0));
    check("rst seq dout",   64'(dout),   64'(0));
    check("rst seq err",    64'(err),    64'(0));
    reset = 1'b0; hready = 1'b1;
    set_ch(0, 1'b0, 32'h48, 32'h0, 4'b0001);
    req[0] = 1'b1;
    ndone = 0; cyc = 0;
    while (ndone < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        check($sformatf("post reset grant %0d", ndone), 64'(done), 64'((ndone == 0) ? 3'b001 : 3'b100));
        $display("txn post-reset%0d done=%b cycle=%0d", ndone, done, cyc);
        if (done[0]) req[0] = 1'b0;
        if (done[2]) req[2] = 1'b0;
        ndone++;
      end
    end
    if (ndone < 2) check("post reset done count", 64'(ndone), 64'(2));
    req = '0;
    @(negedge clk);

`ifdef AHB_TIMEOUT_EN
    // hready held low from the address phase: ends after 8 stalled cycles.
    set_ch(1, 1'b0, 32'h80, 32'h0, 4'b0100);
    hready = 1'b0;
    req[1] = 1'b1;
    cyc = 0; hits = 0; ndone = 0;
    while (ndone == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        ndone = 1;
        check("to done",   64'(done),   64'(3'b010));
        check("to cycle",  64'(cyc),    64'(TO + 1));
        check("to err",    64'(err),    64'(1));
        check("to dout",   64'(dout),   64'(0));
        check("to hsel",   64'(hsel),   64'(0));
        check("to htrans", 64'(htrans), 64'(0));
        check("to nonseq", 64'(hits),   64'(TO));
        $display("txn timeout done=%b cycle=%0d err=%0b", done, cyc, err);
        req[1] = 1'b0;
      end else if (htrans == 2'b10) begin
        hits++;
      end
    end
    if (ndone == 0) check("to done within bound", 64'(0), 64'(1));
    hready = 1'b1;
    @(negedge clk);
`else
    // Long data-phase wait: no completion until hready returns.
    set_ch(1, 1'b0, 32'h80, 32'h0, 4'b0100);
    req[1] = 1'b1;
    @(negedge clk);
    check("long wait addr", 64'(haddr), 64'(32'h80));
    @(negedge clk);
    hready = 1'b0;
    hits = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (done != '0) hits++;
    end
    check("long wait no done", 64'(hits), 64'(0));
    hready = 1'b1; hrdata = 32'h00000077;
    @(negedge clk);
    check("long wait done", 64'(done), 64'(3'b010));
    check("long wait dout", 64'(dout), 64'(32'h77));
    check("long wait err",  64'(err),  64'(0));
    $display("txn long-wait done=%b dout=0x%08h", done, dout);
    req[1] = 1'b0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/ahb_multi_master_arbiter.md
Name: ahb_multi_master_arbiter

Overview:
- Parametrised successor to the fixed three-channel AHB bus front end.
- Accepts single read/write requests from NUM_MASTERS local channels and arbitrates them round-robin.
- Issues each winning request as one non-pipelined AHB-Lite transfer (address phase then data phase) to a one-hot-selected slave, and returns read data and error status to the requesting channel.
- Sits between the local master ports and the slave decode/mux fabric.

Parameters:
- NUM_MASTERS, 3, number of requesting channels (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_SLAVES, 4, width of the one-hot slave select.
- TIMEOUT_CYCLES, 64, wait-state limit; used only with AHB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_MASTERS  per-channel request level; held until the matching done.
- addr  in  NUM_MASTERS*ADDR_W  flattened per-channel address; channel i occupies [i*ADDR_W +: ADDR_W].
- din  in  NUM_MASTERS*DATA_W  flattened per-channel write data.
- wcontrol  in  NUM_MASTERS  1 = write, 0 = read.
- slave_sel  in  NUM_MASTERS*NUM_SLAVES  per-channel one-hot slave select.
- done  out  NUM_MASTERS  one-cycle completion pulse to the granted channel.
- dout  out  DATA_W  read data; valid while any done bit is high.
- err  out  1  error flag; valid with done.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type: 2'b00 IDLE, 2'b10 NONSEQ.
- hwrite  out  1  AHB write.
- hwdata  out  DATA_W  AHB write data.
- hsel  out  NUM_SLAVES  one-hot slave select.
- hrdata  in  DATA_W  AHB read data.
- hready  in  1  AHB ready.
- hresp  in  1  AHB response: 0 OKAY, 1 ERROR.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Round-robin pointer goes to NUM_MASTERS-1, so channel 0 has first priority.
  - done=0, dout=0, err=0, haddr=0, htrans=IDLE, hwrite=0, hwdata=0, hsel=0.
  - Reset mid-transfer abandons the transfer immediately with no done pulse. The slave sees htrans=IDLE on the next cycle.
- Arbitration (IDLE state):
  - Search req starting at pointer+1, wrapping modulo NUM_MASTERS; the first set bit wins.
  - On a win, register grant index, addr, din, wcontrol and slave_sel.
  - If slave_sel is one-hot, go to ADDR. If it is zero or multi-hot, go to DONE with err=1 and issue no bus cycle.
  - No req set: remain in IDLE.
- ADDR state:
  - Drive htrans=NONSEQ, haddr, hwrite and hsel from the registered request.
  - Advance to DATA when hready=1; otherwise hold all outputs.
- DATA state:
  - Drive htrans=IDLE and hwdata=registered din. hsel stays asserted.
  - When hready=1: capture hrdata (reads only; writes capture 0) and hresp into err, then go to DONE.
  - hready=0 holds the state, unbounded unless the optional feature is enabled.
- DONE state (one cycle):
  - done[grant]=1; dout and err are valid.
  - Pointer becomes grant.
  - htrans=IDLE, hsel=0.
  - Next state is IDLE.
- Latency and request handshake:
  - With zero wait states, done rises 3 cycles after the IDLE cycle that sampled req.
  - Each wait state adds 1 cycle.
  - A channel deasserts req on the edge that ends its done cycle; IDLE samples the updated req.
  - A req still high after done is treated as a new request.
- Request stability:
  - Changes to a granted channel's addr/din after grant have no effect.
  - Ungranted channels wait with no timeout.
- Fairness:
  - With all channels requesting continuously, grants rotate 0,1,2,...
  - A channel is never granted twice while another channel is requesting.
- Single-channel case: NUM_MASTERS=1 degenerates to pointer-free operation with identical timing.

Optional Feature:
- AHB_TIMEOUT_EN defined:
  - A wait counter clears on entry to ADDR and counts cycles with hready=0 in ADDR or DATA.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and dout=0, and drive htrans=IDLE and hsel=0.
- AHB_TIMEOUT_EN undefined: no counter is built and waits are unbounded.

Decomposition:
- Package ahb_pkg holds:
  - htrans encodings HTRANS_IDLE and HTRANS_NONSEQ;
  - HRESP_OKAY and HRESP_ERROR;
  - the state enum IDLE/ADDR/DATA/DONE;
  - an is_onehot function.
- Sub-module rr_arbiter (parameter N) takes req, pointer and an update strobe, and returns the grant index plus an any-request flag.

Test Plan:
- Single read, zero wait: ch1 reads addr 0x10, slave_sel 4'b0010, hrdata=0xDEADBEEF. Expect htrans=NONSEQ with haddr=0x10 one cycle, then done[1] 3 cycles after req with dout=0xDEADBEEF, err=0.
- Write with 2 wait states: ch0 writes 0xA5A5A5A5, hready low 2 cycles in DATA. Expect hwdata stable throughout and done[0] at cycle 5.
- Contention: req=3'b111 held continuously. Expect grant order 0,1,2,0 with done pulses spaced 4 cycles apart.
- Error paths:
  - hresp=1 in DATA gives done with err=1.
  - slave_sel=4'b0110 gives done 1 cycle after IDLE with err=1 and htrans never NONSEQ.
- Reset mid-DATA: reset asserted during a hready-low wait. Expect no done pulse, all outputs at reset values next cycle, and the next grant going to channel 0.
- AHB_TIMEOUT_EN, TIMEOUT_CYCLES=8: hready held low. Expect done with err=1 exactly 8 wait cycles after ADDR entry, and hsel=0 after it.
